// File: rtl/dma_regfile_mc_if.sv
// APB slave bundle for the multi-channel DMA register file.
// pclken is carried with the bus because it qualifies every APB handshake.
interface dma_regfile_mc_if #(
   parameter int ADDR_BITS = 16
);
   logic                 pclken;
   logic                 psel;
   logic                 penable;
   logic [ADDR_BITS-1:0] paddr;
   logic                 pwrite;
   logic [31:0]          pwdata;
   logic [31:0]          prdata;
   logic                 pslverr;
   logic                 pready;

   modport master (
      output pclken, psel, penable, paddr, pwrite, pwdata,
      input  prdata, pslverr, pready
   );

   modport slave (
      input  pclken, psel, penable, paddr, pwrite, pwdata,
      output prdata, pslverr, pready
   );
endinterface

// File: rtl/dma_regfile_mc.sv
// Multi-channel APB register file for the DMA engine: per-channel address/size/command
// registers, W1C interrupt status with enable mask, optional read wait state and pslverr.
module dma_regfile_mc #(
   parameter int ADDR_BITS = 16,
   parameter int NUM_CH    = 4,
   parameter int CNT_BITS  = 16,
   parameter int READ_WAIT = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   dma_regfile_mc_if.slave            apb,
   input  logic [NUM_CH*CNT_BITS-1:0] buffer_count,
   input  logic [NUM_CH*CNT_BITS-1:0] int_count,
   input  logic [NUM_CH-1:0]          ch_busy,
   input  logic [NUM_CH-1:0]          ch_done,
   output logic [NUM_CH*32-1:0]       rd_start_addr,
   output logic [NUM_CH*32-1:0]       wr_start_addr,
   output logic [NUM_CH*32-1:0]       buffer_size,
   output logic [NUM_CH-1:0]          cmd_last,
   output logic [NUM_CH*28-1:0]       next_addr,
   output logic [NUM_CH-1:0]          wr_ch_start,
   output logic                       set_int
);
   typedef enum logic {S_IDLE, S_RDY} state_t;

   localparam logic [ADDR_BITS-9:0] GLOB_PAGE = (ADDR_BITS-8)'(1);
   localparam logic [31:0] ID_VALUE = {16'h0DA2, 8'(NUM_CH), 8'(CNT_BITS)};

   state_t state, state_nxt;

   logic [31:0]       rd_start_q [NUM_CH];
   logic [31:0]       wr_start_q [NUM_CH];
   logic [31:0]       size_q     [NUM_CH];
   logic [27:0]       next_q     [NUM_CH];
   logic [NUM_CH-1:0] last_q, start_q, int_stat_q, int_en_q, clear_mask;
   logic              set_int_q;
   logic [31:0]       rdata_q, rd_value;
   logic              err_q;
   logic [2:0]        ch_sel, reg_sel;
   logic [5:0]        glob_sel;
   logic              chan_region, glob_region, mapped, read_only, is_cmd, busy_sel;
   logic              err_now, wr_accept, rd_launch;
   logic              unused_bits;

   assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[3:2]};

   // Address decode and read mux; channels beyond NUM_CH never match and stay unmapped.
   always_comb begin
      ch_sel      = apb.paddr[7:5];
      reg_sel     = apb.paddr[4:2];
      glob_sel    = apb.paddr[7:2];
      chan_region = (apb.paddr[ADDR_BITS-1:8] == '0);
      glob_region = (apb.paddr[ADDR_BITS-1:8] == GLOB_PAGE);
      rd_value    = '0;
      mapped      = 1'b0;
      read_only   = 1'b0;
      is_cmd      = 1'b0;
      busy_sel    = 1'b0;
      if (chan_region) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 3'(c)) begin
               mapped   = (reg_sel <= 3'd4);
               busy_sel = ch_busy[c];
               case (reg_sel)
                  3'd0:    rd_value = rd_start_q[c];
                  3'd1:    rd_value = wr_start_q[c];
                  3'd2:    rd_value = size_q[c];
                  3'd3:    rd_value = {next_q[c], 2'b00, last_q[c], 1'b0};
                  3'd4:    rd_value = {16'(int_count[c*CNT_BITS +: CNT_BITS]),
                                       16'(buffer_count[c*CNT_BITS +: CNT_BITS])};
                  default: rd_value = '0;
               endcase
            end
         end
         read_only = (reg_sel == 3'd4);
         is_cmd    = (reg_sel == 3'd3);
      end else if (glob_region) begin
         case (glob_sel)
            6'd0: begin
               mapped   = 1'b1;
               rd_value = 32'(int_stat_q);
            end
            6'd1: begin
               mapped   = 1'b1;
               rd_value = 32'(int_en_q);
            end
            6'd2: begin
               mapped    = 1'b1;
               read_only = 1'b1;
               rd_value  = ID_VALUE;
            end
            default: ;
         endcase
      end
      err_now    = ~mapped | (apb.pwrite & read_only)
                 | (apb.pwrite & is_cmd & apb.pwdata[0] & busy_sel);
      wr_accept  = apb.pclken & apb.psel & apb.penable & apb.pwrite & ~err_now
                 & (state == S_IDLE);
      clear_mask = (wr_accept && glob_region && glob_sel == 6'd0) ?
                   apb.pwdata[NUM_CH-1:0] : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           state <= S_IDLE;
      else if (apb.pclken)  state <= state_nxt;
   end

   // Writes always complete in S_IDLE; reads take a detour through S_RDY when waited.
   always_comb begin
      state_nxt   = state;
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = '0;
      rd_launch   = 1'b0;
      case (state)
         S_IDLE: begin
            if (apb.psel && apb.penable) begin
               if (apb.pwrite || READ_WAIT == 0) begin
                  apb.pready  = reset;
                  apb.pslverr = reset & err_now;
                  if (!apb.pwrite && reset) apb.prdata = rd_value;
               end else begin
                  rd_launch = 1'b1;
                  state_nxt = S_RDY;
               end
            end
         end
         S_RDY: begin
            apb.pready  = 1'b1;
            apb.pslverr = err_q;
            apb.prdata  = rdata_q;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (apb.pclken && rd_launch) begin
         rdata_q <= rd_value;
         err_q   <= err_now;
      end
   end

   // Channel registers; START is only a one-cycle pulse and never stored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            rd_start_q[c] <= '0;
            wr_start_q[c] <= '0;
            size_q[c]     <= '0;
            next_q[c]     <= '0;
         end
         last_q   <= '0;
         start_q  <= '0;
         int_en_q <= '0;
      end else begin
         start_q <= '0;
         if (wr_accept && chan_region) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (ch_sel == 3'(c)) begin
                  case (reg_sel)
                     3'd0: rd_start_q[c] <= apb.pwdata;
                     3'd1: wr_start_q[c] <= apb.pwdata;
                     3'd2: size_q[c]     <= apb.pwdata;
                     3'd3: begin
                        next_q[c]  <= apb.pwdata[31:4];
                        last_q[c]  <= apb.pwdata[1];
                        start_q[c] <= apb.pwdata[0];
                     end
                     default: ;
                  endcase
               end
            end
         end
         if (wr_accept && glob_region && glob_sel == 6'd1)
            int_en_q <= apb.pwdata[NUM_CH-1:0];
      end
   end

   // ch_done is OR-ed in after the W1C clear so a coincident completion is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         int_stat_q <= '0;
         set_int_q  <= 1'b0;
      end else begin
         int_stat_q <= (int_stat_q & ~clear_mask) | ch_done;
         set_int_q  <= |(int_stat_q & int_en_q);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_out
      assign rd_start_addr[c*32 +: 32] = rd_start_q[c];
      assign wr_start_addr[c*32 +: 32] = wr_start_q[c];
      assign buffer_size[c*32 +: 32]   = size_q[c];
      assign next_addr[c*28 +: 28]     = next_q[c];
   end

   assign cmd_last    = last_q;
   assign wr_ch_start = start_q;
   assign set_int     = set_int_q;
endmodule

// File: tb/tb_dma_regfile_mc.sv
// Directed bench for dma_regfile_mc: APB responses are checked by a scoreboard monitor,
// sideband outputs by direct comparisons against hand-computed constants.
module tb_dma_regfile_mc;
   localparam int NUM_CH   = 4;
   localparam int CNT_BITS = 16;

   typedef struct {
      logic [31:0] data;
      logic        err;
      string       name;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [63:0]    buffer_count, int_count;
   logic [3:0]     ch_busy, ch_done;
   logic [127:0]   rd_start_addr, wr_start_addr, buffer_size;
   logic [3:0]     cmd_last, wr_ch_start;
   logic [111:0]   next_addr;
   logic           set_int;

   int             checks = 0;
   int             errors = 0;
   exp_t           sb_q[$];

   dma_regfile_mc_if #(.ADDR_BITS(16)) apb ();

   dma_regfile_mc #(
      .ADDR_BITS(16), .NUM_CH(NUM_CH), .CNT_BITS(CNT_BITS), .READ_WAIT(1)
   ) dut (
      .clk(clk), .reset(reset), .apb(apb),
      .buffer_count(buffer_count), .int_count(int_count),
      .ch_busy(ch_busy), .ch_done(ch_done),
      .rd_start_addr(rd_start_addr), .wr_start_addr(wr_start_addr),
      .buffer_size(buffer_size), .cmd_last(cmd_last), .next_addr(next_addr),
      .wr_ch_start(wr_ch_start), .set_int(set_int)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: one pop per completed APB transfer (pready at a pclken edge).
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && apb.pclken && apb.psel && apb.penable && apb.pready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_response: got prdata=%h pslverr=%b, required none",
                        apb.prdata, apb.pslverr);
            end else begin
               e = sb_q.pop_front();
               if (apb.prdata !== e.data || apb.pslverr !== e.err) begin
                  errors++;
                  $display("[TB] FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                           e.name, apb.prdata, apb.pslverr, e.data, e.err);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic push_expected(input logic [31:0] data, input logic err, input string name);
      exp_t e;
      e.data = data;
      e.err  = err;
      e.name = name;
      sb_q.push_back(e);
   endtask

   // Waits for pready with a bounded budget, then closes the access after the completing edge.
   task automatic finish_access(input string name);
      int n = 0;
      @(negedge clk);
      while (!apb.pready && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!apb.pready) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got pready=0, required pready=1", name);
      end
      @(posedge clk); #1;
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      apb.pwrite  = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [15:0] addr, input logic wr, input logic [31:0] data,
                                 input logic [31:0] exp_data, input logic exp_err,
                                 input string name);
      push_expected(exp_data, exp_err, name);
      @(posedge clk); #1;
      apb.pclken  = 1'b1;
      apb.psel    = 1'b1;
      apb.penable = 1'b0;
      apb.paddr   = addr;
      apb.pwrite  = wr;
      apb.pwdata  = data;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      finish_access(name);
   endtask

   initial begin
      reset        = 1'b0;
      apb.pclken   = 1'b1;
      apb.psel     = 1'b1;
      apb.penable  = 1'b1;
      apb.pwrite   = 1'b1;
      apb.paddr    = 16'h0000;
      apb.pwdata   = 32'hFFFF_FFFF;
      buffer_count = '0;
      int_count    = '0;
      ch_busy      = '0;
      ch_done      = '0;

      // Reset holds everything at zero even with a write presented on the bus
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_pready", 128'(apb.pready), 128'(0));
      check_output("reset_pslverr", 128'(apb.pslverr), 128'(0));
      check_output("reset_rd_start", rd_start_addr, '0);
      check_output("reset_wr_start", wr_start_addr, '0);
      check_output("reset_misc", {buffer_size[15:0], next_addr[15:0], cmd_last, wr_ch_start,
                                  3'b000, set_int}, '0);
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      apply_stimulus(16'h0000, 1'b0, 32'h0, 32'h0, 1'b0, "rd_start0_after_reset");

      // ch1 WR_START write and readback
      apply_stimulus(16'h0024, 1'b1, 32'h0000_002B, 32'h0, 1'b0, "wr_start1_write");
      check_output("wr_start_addr_ch1", wr_start_addr, 128'h0000_0000_0000_0000_0000_002B_0000_0000);
      apply_stimulus(16'h0024, 1'b0, 32'h0, 32'h0000_002B, 1'b0, "wr_start1_read");

      // ch2 CMD with START: one-cycle pulse, LAST and NEXT_ADDR stored
      apply_stimulus(16'h004C, 1'b1, 32'h0000_1233, 32'h0, 1'b0, "cmd2_write");
      check_output("start_pulse_ch2", 128'(wr_ch_start), 128'(4'b0100));
      check_output("cmd_last_ch2", 128'(cmd_last), 128'(4'b0100));
      check_output("next_addr_ch2", 128'(next_addr[56 +: 28]), 128'(28'h000_0123));
      @(posedge clk); #1;
      check_output("start_pulse_ends", 128'(wr_ch_start), 128'(0));
      apply_stimulus(16'h004C, 1'b0, 32'h0, 32'h0000_1232, 1'b0, "cmd2_read");

      // Start-while-busy is rejected without side effects
      ch_busy = 4'b0100;
      apply_stimulus(16'h004C, 1'b1, 32'h0000_5671, 32'h0, 1'b1, "cmd2_busy_write");
      check_output("busy_no_pulse", 128'(wr_ch_start), 128'(0));
      @(posedge clk); #1;
      check_output("busy_no_pulse_late", 128'(wr_ch_start), 128'(0));
      check_output("busy_next_addr_kept", 128'(next_addr[56 +: 28]), 128'(28'h000_0123));
      ch_busy = 4'b0000;
      apply_stimulus(16'h004C, 1'b0, 32'h0, 32'h0000_1232, 1'b0, "cmd2_read_after_busy");

      // Error responses
      apply_stimulus(16'h0090, 1'b1, 32'h1234_5678, 32'h0, 1'b1, "write_ch4_absent");
      apply_stimulus(16'h0090, 1'b0, 32'h0, 32'h0, 1'b1, "read_ch4_absent");
      apply_stimulus(16'h0010, 1'b1, 32'h1234_5678, 32'h0, 1'b1, "write_status0");
      apply_stimulus(16'h0014, 1'b0, 32'h0, 32'h0, 1'b1, "read_ch0_hole");
      apply_stimulus(16'h0108, 1'b1, 32'h0, 32'h0, 1'b1, "write_id");
      apply_stimulus(16'h0108, 1'b0, 32'h0, 32'h0DA2_0410, 1'b0, "read_id");
      apply_stimulus(16'h010C, 1'b0, 32'h0, 32'h0, 1'b1, "read_global_hole");
      check_output("rejected_writes_no_change", {rd_start_addr[31:0], buffer_size[31:0]}, '0);

      // Interrupt path; ch_done acts even with pclken low
      apply_stimulus(16'h0104, 1'b1, 32'hFFFF_FFF3, 32'h0, 1'b0, "int_en_write");
      apply_stimulus(16'h0104, 1'b0, 32'h0, 32'h0000_0003, 1'b0, "int_en_read");
      @(posedge clk); #1;
      apb.pclken = 1'b0;
      ch_done    = 4'b0001;
      @(posedge clk); #1;
      ch_done    = 4'b0000;
      check_output("set_int_not_yet", 128'(set_int), 128'(0));
      @(posedge clk); #1;
      check_output("set_int_raised", 128'(set_int), 128'(1));
      apply_stimulus(16'h0100, 1'b0, 32'h0, 32'h0000_0001, 1'b0, "int_stat_read");
      ch_done = 4'b0001;
      apply_stimulus(16'h0100, 1'b1, 32'h0000_0001, 32'h0, 1'b0, "w1c_with_done");
      ch_done = 4'b0000;
      apply_stimulus(16'h0100, 1'b0, 32'h0, 32'h0000_0001, 1'b0, "int_stat_set_wins");
      apply_stimulus(16'h0100, 1'b1, 32'h0000_0001, 32'h0, 1'b0, "w1c_plain");
      @(posedge clk); #1;
      check_output("set_int_cleared", 128'(set_int), 128'(0));
      apply_stimulus(16'h0100, 1'b0, 32'h0, 32'h0, 1'b0, "int_stat_cleared");

      // pclken low: a held write must not commit
      @(posedge clk); #1;
      apb.pclken = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
      apb.paddr  = 16'h0008; apb.pwrite = 1'b1; apb.pwdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("frozen_write_no_commit", 128'(buffer_size[31:0]), 128'(0));
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pclken = 1'b1;

      // pclken low: a held read never reaches the wait state
      @(posedge clk); #1;
      apb.pclken = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
      apb.paddr  = 16'h0024; apb.pwrite = 1'b0;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("frozen_read_no_pready", 128'(apb.pready), 128'(0));
      push_expected(32'h0000_002B, 1'b0, "read_after_freeze");
      apb.pclken = 1'b1;
      finish_access("read_after_freeze");

      // STATUS packing
      buffer_count = 64'h1111_0000_0000_0020;
      int_count    = 64'h2222_0000_0000_0020;
      apply_stimulus(16'h0010, 1'b0, 32'h0, 32'h0020_0020, 1'b0, "status0_read");
      apply_stimulus(16'h0070, 1'b0, 32'h0, 32'h2222_1111, 1'b0, "status3_read");

      repeat (2) @(posedge clk);
      #1;
      check_output("scoreboard_drained", 128'(sb_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dma_regfile_mc.md
Name: dma_regfile_mc

Overview:
- Multi-channel APB register file for the DMA engine; successor to the single-channel DMA register file.
- Holds per-channel read/write start addresses, buffer size and command, generated for NUM_CH channels.
- Adds an optional read wait state, pslverr on bad accesses, start-while-busy protection and a maskable interrupt status register.
- Sits between the APB bus (qualified by pclken) and the DMA channel engines.

Parameters:
ADDR_BITS, 16, APB address width (byte addresses; bits [1:0] ignored)
NUM_CH, 4, number of DMA channels (1..8)
CNT_BITS, 16, width of each per-channel buffer_count / int_count status field
READ_WAIT, 1, 0 = zero-wait reads, 1 = one wait state on every read

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (reset=0 clears all state)
pclken  in  1  APB clock enable; the APB protocol advances only on clk edges with pclken=1
psel  in  1  APB select
penable  in  1  APB enable (access phase)
paddr  in  ADDR_BITS  APB byte address
pwrite  in  1  1 = write
pwdata  in  32  write data
prdata  out  32  read data, valid when pready=1 and read
pslverr  out  1  error response, valid only with pready=1
pready  out  1  transfer complete
buffer_count  in  NUM_CH*CNT_BITS  per-channel transferred count, ch0 in LSBs
int_count  in  NUM_CH*CNT_BITS  per-channel interrupt count
ch_busy  in  NUM_CH  channel engine active
ch_done  in  NUM_CH  one-cycle completion pulse per channel
rd_start_addr  out  NUM_CH*32  per-channel read start address
wr_start_addr  out  NUM_CH*32  per-channel write start address
buffer_size  out  NUM_CH*32  per-channel buffer size
cmd_last  out  NUM_CH  per-channel last-command flag
next_addr  out  NUM_CH*28  per-channel next descriptor address
wr_ch_start  out  NUM_CH  one-cycle start pulse per channel
set_int  out  1  interrupt = |(int_stat & int_en)

Behaviour:
- Reset (reset=0, async):
  - all registers, prdata, wr_ch_start, set_int and int_stat/int_en = 0
  - FSM to S_IDLE; pready=0, pslverr=0 while in reset
  - reset mid-transfer abandons the transfer; no register is written.
- Per-channel map, channel c at base c*0x20:
  - 0x00 RD_START RW; 0x04 WR_START RW; 0x08 BUFFER_SIZE RW
  - 0x0C CMD RW: bit0 START (self-clearing, reads 0), bit1 LAST, bits[31:4] NEXT_ADDR
  - 0x10 STATUS RO: {int_count[c], buffer_count[c]}, each zero-extended/truncated to 16 bits.
- Global registers:
  - 0x100 INT_STAT, W1C, bit c per channel
  - 0x104 INT_EN, RW, bits[NUM_CH-1:0]
  - 0x108 ID RO = {16'h0DA2, 8'(NUM_CH), 8'(CNT_BITS)}.
- Access FSM (state advances only on clk edges with pclken=1):
  - S_IDLE: pready = psel & penable & (pwrite | READ_WAIT==0). prdata is driven combinationally from the addressed register.
  - S_IDLE with READ_WAIT=1 and psel & penable & ~pwrite: pready=0; latch read data and error into rdata_q/err_q; go to S_RDY.
  - S_RDY: pready=1, prdata=rdata_q, pslverr=err_q; next pclken edge returns to S_IDLE.
  - prdata=0 whenever pready=0 or the access is a write.
- pslverr=1 (with pready=1) when any of the following holds; a rejected write changes no state:
  - unmapped address
  - channel index >= NUM_CH
  - write to STATUS or ID
  - CMD write with START=1 while ch_busy[c]=1.
- Write commit on the clk edge with pclken & psel & penable & pwrite & ~pslverr; the new value is visible on outputs the next cycle.
- wr_ch_start[c] pulses high exactly one clk cycle after an accepted CMD write with START=1.
  - LAST and NEXT_ADDR update in the same write.
- INT_STAT[c] is set by ch_done[c] on any clk edge, independent of pclken.
  - A simultaneous W1C clear and ch_done on the same bit: set wins.
- set_int is registered: it reflects INT_STAT & INT_EN one cycle after either changes.
- Unused upper bits of INT_STAT/INT_EN read 0 and ignore writes.

Test Plan:
- Reset: drive reset=0 then 1 -> all outputs 0; read RD_START ch0 returns 0, pready=1 on second pclken access cycle (READ_WAIT=1), pslverr=0.
- Write 0x0000002B to 0x24 (ch1 WR_START) with pclken=1 -> wr_start_addr[63:32]=0x2B next cycle, other channels unchanged; readback after one wait state returns 0x2B.
- CMD write 0x00001233 to ch2 (0x4C), ch_busy=0 -> wr_ch_start=4'b0100 for one cycle, cmd_last[2]=1, next_addr[2]=0x0000123; CMD readback = 0x00001232.
- Same CMD write with ch_busy[2]=1 -> pslverr=1, no wr_ch_start pulse, registers unchanged; write to 0x90 (ch4, NUM_CH=4) or 0x10 STATUS -> pslverr=1.
- INT_EN=0x3, ch_done[0] pulse -> INT_STAT=0x1, set_int=1 one cycle later; W1C 0x1 coincident with a new ch_done[0] -> INT_STAT stays 0x1; plain W1C 0x1 -> set_int=0.
- pclken=0 with psel/penable held -> no write, FSM frozen; buffer_count[CNT_BITS-1:0]=0x20, int_count=0x20 -> STATUS ch0 reads 0x00200020.
